// File: rtl/rmt_pkt_filter_pkg.sv
// Shared constants, enums and helpers for the ingress packet filter.
// Header constants are stored byte-swapped so they compare directly against
// tdata, where byte 0 sits at tdata[7:0].
package rmt_filter_pkg;

  localparam logic [15:0] TPID_VLAN_SW    = 16'h0081;
  localparam logic [15:0] ETHTYPE_IPV4_SW = 16'h0008;
  localparam logic [7:0]  PROT_UDP        = 8'h11;

  typedef enum logic {
    DATA = 1'b0,
    CTRL = 1'b1
  } route_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FWD  = 2'd2,
    DROP = 2'd3
  } state_e;

  // Converts a network-order 16-bit field into the order it has on tdata.
  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

endpackage

// File: rtl/rmt_pkt_filter_if.sv
// AXI-Stream bundle used for the filter's ingress, data and control streams.
// Ports: tdata/tuser/tkeep/tlast payload, tvalid/tready handshake.
// master drives payload and tvalid; slave drives tready.
interface rmt_pkt_filter_if #(
  parameter int DW = 256,
  parameter int UW = 128
) ();
  logic [DW-1:0]   tdata;
  logic [UW-1:0]   tuser;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tuser, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tuser, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_pkt_filter_classify.sv
// Combinational classifier on the first two beats of a packet.
// Ports: i_beat1/i_beat2 tdata of beats 1 and 2; o_drop = not VLAN/IPv4;
// o_is_ctrl = VLAN/IPv4/UDP addressed to CTRL_UDP_PORT.
module pkt_classify
  import rmt_filter_pkg::*;
#(
  parameter logic [15:0] CTRL_UDP_PORT = 16'hf1f2
) (
  input  logic [255:0] i_beat1,
  input  logic [255:0] i_beat2,
  output logic         o_drop,
  output logic         o_is_ctrl
);

  logic w_vlan_ipv4;
  logic w_udp_ctrl;

  assign w_vlan_ipv4 = (i_beat1[96+:16] == TPID_VLAN_SW) &&
                       (i_beat1[128+:16] == ETHTYPE_IPV4_SW);
  // UDP dst port lands in beat 2 bytes 8-9
  assign w_udp_ctrl  = (i_beat1[216+:8] == PROT_UDP) &&
                       (i_beat2[64+:16] == swap16(CTRL_UDP_PORT));

  assign o_drop    = !w_vlan_ipv4;
  assign o_is_ctrl = w_vlan_ipv4 && w_udp_ctrl;

endmodule

// File: rtl/rmt_pkt_filter.sv
// Ingress filter: routes each packet to the data stream, the control stream
// or drops it, based on its first two beats. Optional FILTER_STATS_EN adds
// per-route packet counters. Ports: s_axis in, m_axis data out, ctrl_m_axis
// control out (always accepted), stat_* counters.
module rmt_pkt_filter
  import rmt_filter_pkg::*;
#(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2
) (
  input  logic                    axis_clk,
  input  logic                    aresetn,
  rmt_pkt_filter_if.slave         s_axis,
  rmt_pkt_filter_if.master        m_axis,
  rmt_pkt_filter_if.master        ctrl_m_axis,
  output logic [31:0]             stat_data_cnt,
  output logic [31:0]             stat_ctrl_cnt,
  output logic [31:0]             stat_drop_cnt
);

  typedef struct packed {
    logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic                             tlast;
  } beat_t;

  state_e r_state;
  beat_t  r_h;
  logic   r_h_v;
  route_e r_h_rt;
  beat_t  r_s;
  logic   r_s_v;
  logic   r_got_last;   // tlast of the current packet already accepted

  beat_t  w_in;
  logic   w_emit;
  logic   w_final;
  logic   w_rdy;
  logic   w_acc;
  logic   w_drop;
  logic   w_ctrl;

  assign w_in = {s_axis.tdata, s_axis.tuser, s_axis.tkeep, s_axis.tlast};

  pkt_classify #(.CTRL_UDP_PORT(CTRL_UDP_PORT)) u_classify (
    .i_beat1   (r_h.tdata),
    .i_beat2   (s_axis.tdata),
    .o_drop    (w_drop),
    .o_is_ctrl (w_ctrl)
  );

  assign w_emit  = r_h_v && (r_state != HOLD) && ((r_h_rt == CTRL) || m_axis.tready);
  assign w_final = w_emit && r_h.tlast;

  // Once tlast is in, only the final emit frees H for the next packet's beat 1
  always_comb begin
    w_rdy = 1'b1;
    case (r_state)
      IDLE:    w_rdy = !r_h_v || w_emit;
      HOLD:    w_rdy = 1'b1;
      FWD:     w_rdy = r_got_last ? w_final : (!r_h_v || w_emit);
      DROP:    w_rdy = 1'b1;
      default: w_rdy = 1'b1;
    endcase
  end

  assign w_acc         = s_axis.tvalid && w_rdy;
  assign s_axis.tready = w_rdy;

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_h        <= '0;
      r_h_v      <= 1'b0;
      r_h_rt     <= DATA;
      r_s        <= '0;
      r_s_v      <= 1'b0;
      r_got_last <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // single-beat packets are too short to classify and vanish here
          if (w_acc && !s_axis.tlast) begin
            r_h        <= w_in;
            r_h_v      <= 1'b1;
            r_got_last <= 1'b0;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          if (w_acc) begin
            if (w_drop) begin
              r_h_v   <= 1'b0;
              r_state <= s_axis.tlast ? IDLE : DROP;
            end else begin
              r_h_rt     <= w_ctrl ? CTRL : DATA;
              r_s        <= w_in;
              r_s_v      <= 1'b1;
              r_got_last <= s_axis.tlast;
              r_state    <= FWD;
            end
          end
        end
        FWD: begin
          if (w_final) begin
            r_h_v   <= 1'b0;
            r_s_v   <= 1'b0;
            r_state <= IDLE;
            // next packet's first beat may arrive while the tail leaves
            if (w_acc && !s_axis.tlast) begin
              r_h        <= w_in;
              r_h_v      <= 1'b1;
              r_got_last <= 1'b0;
              r_state    <= HOLD;
            end
          end else begin
            if (w_acc) r_got_last <= s_axis.tlast;
            if (w_emit) begin
              if (r_s_v) begin
                r_h <= r_s;
                if (w_acc) r_s <= w_in;
                else       r_s_v <= 1'b0;
              end else if (w_acc) begin
                r_h <= w_in;
              end else begin
                r_h_v <= 1'b0;
              end
            end else if (w_acc) begin
              // only reachable with both slots empty after an upstream gap
              r_h   <= w_in;
              r_h_v <= 1'b1;
            end
          end
        end
        DROP: begin
          if (w_acc && s_axis.tlast) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = r_h.tdata;
  assign m_axis.tuser  = r_h.tuser;
  assign m_axis.tkeep  = r_h.tkeep;
  assign m_axis.tlast  = r_h.tlast;
  assign m_axis.tvalid = r_h_v && (r_h_rt == DATA) && (r_state != HOLD);

  assign ctrl_m_axis.tdata  = r_h.tdata;
  assign ctrl_m_axis.tuser  = r_h.tuser;
  assign ctrl_m_axis.tkeep  = r_h.tkeep;
  assign ctrl_m_axis.tlast  = r_h.tlast;
  assign ctrl_m_axis.tvalid = r_h_v && (r_h_rt == CTRL) && (r_state != HOLD);

`ifdef FILTER_STATS_EN
  logic [31:0] r_data_cnt;
  logic [31:0] r_ctrl_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_short;
  logic        w_cls;

  assign w_short = w_acc && s_axis.tlast &&
                   ((r_state == IDLE) || ((r_state == FWD) && w_final));
  assign w_cls   = w_acc && (r_state == HOLD);

  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      r_data_cnt <= '0;
      r_ctrl_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_short || (w_cls && w_drop))      r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_cls && !w_drop && !w_ctrl)       r_data_cnt <= r_data_cnt + 32'd1;
      if (w_cls && !w_drop && w_ctrl)        r_ctrl_cnt <= r_ctrl_cnt + 32'd1;
    end
  end

  assign stat_data_cnt = r_data_cnt;
  assign stat_ctrl_cnt = r_ctrl_cnt;
  assign stat_drop_cnt = r_drop_cnt;
`else
  assign stat_data_cnt = '0;
  assign stat_ctrl_cnt = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rmt_pkt_filter.sv
// Directed bench for rmt_pkt_filter: data, control, drop, stall, back-to-back
// and mid-packet reset cases, checked against hand-built expected beats.
module tb_rmt_pkt_filter;

  typedef struct packed {
    logic [255:0] d;
    logic [127:0] u;
    logic [31:0]  k;
    logic         l;
  } tb_beat_t;

`ifdef FILTER_STATS_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  logic axis_clk = 1'b0;
  logic aresetn;
  logic [31:0] st_d, st_c, st_dr;

  always #5 axis_clk = ~axis_clk;

  rmt_pkt_filter_if s_if ();
  rmt_pkt_filter_if m_if ();
  rmt_pkt_filter_if c_if ();

  rmt_pkt_filter dut (
    .axis_clk      (axis_clk),
    .aresetn       (aresetn),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .ctrl_m_axis   (c_if),
    .stat_data_cnt (st_d),
    .stat_ctrl_cnt (st_c),
    .stat_drop_cnt (st_dr)
  );

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  bit tog = 0;
  tb_beat_t mq[$], cq[$], em[$], ec[$];
  tb_beat_t b;
  tb_beat_t m_cur, c_cur, stall_beat;
  logic stall_prev = 1'b0;

  assign m_cur = {m_if.tdata, m_if.tuser, m_if.tkeep, m_if.tlast};
  assign c_cur = {c_if.tdata, c_if.tuser, c_if.tkeep, c_if.tlast};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic tb_beat_t mk_beat(input int p, input int i, input int n,
                                       input bit vlan, input bit udp,
                                       input logic [15:0] port);
    tb_beat_t r;
    r.d = {8{8'hA5, p[7:0], i[7:0], 8'h3C}};
    r.u = {4{24'hC0FFEE, p[3:0], i[3:0]}};
    r.k = (i == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    r.l = (i == n - 1);
    if (i == 0) begin
      r.d[96+:16]  = vlan ? 16'h0081 : 16'h0008;
      r.d[128+:16] = 16'h0008;
      r.d[216+:8]  = udp ? 8'h11 : 8'h06;
    end
    if (i == 1) r.d[64+:16] = {port[7:0], port[15:8]};
    return r;
  endfunction

  // Output monitor and stall-stability check, sampled mid-cycle.
  always @(negedge axis_clk) begin
    if (aresetn) begin
      if (stall_prev) begin
        chk("stall_vld", m_if.tvalid, 1'b1);
        chk("stall_dat", m_cur.d, stall_beat.d);
        chk("stall_meta", {m_cur.u, m_cur.k, m_cur.l}, {stall_beat.u, stall_beat.k, stall_beat.l});
      end
      if (m_if.tvalid && m_if.tready) mq.push_back(m_cur);
      if (c_if.tvalid) cq.push_back(c_cur);
      stall_prev <= m_if.tvalid && !m_if.tready;
      stall_beat <= m_cur;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  task automatic send_beat(input tb_beat_t bt);
    bit ok;
    ok = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = bt.d;
    s_if.tuser  = bt.u;
    s_if.tkeep  = bt.k;
    s_if.tlast  = bt.l;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge axis_clk);
      ok = s_if.tready;
      @(posedge axis_clk);
      #1;
      if (tog) m_if.tready = ~m_if.tready;
      if (!ok) stall_cnt++;
    end
    if (!ok) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  // route: 0 data, 1 control, 2 dropped
  task automatic send_pkt(input int p, input int n, input bit vlan, input bit udp,
                          input logic [15:0] port, input int route);
    tb_beat_t x;
    for (int i = 0; i < n; i++) begin
      x = mk_beat(p, i, n, vlan, udp, port);
      if (route == 0) em.push_back(x);
      if (route == 1) ec.push_back(x);
      send_beat(x);
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 60; w++) begin
      if (mq.size() >= em.size() && cq.size() >= ec.size()) break;
      @(posedge axis_clk);
      #1;
      if (tog) m_if.tready = ~m_if.tready;
    end
    repeat (3) begin
      @(posedge axis_clk);
      #1;
    end
    tog = 1'b0;
    m_if.tready = 1'b1;
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_mcnt"}, mq.size(), em.size());
    for (int i = 0; i < em.size() && i < mq.size(); i++) begin
      chk($sformatf("%s_md%0d", tag, i), mq[i].d, em[i].d);
      chk($sformatf("%s_mm%0d", tag, i), {mq[i].u, mq[i].k, mq[i].l}, {em[i].u, em[i].k, em[i].l});
    end
    chk({tag, "_ccnt"}, cq.size(), ec.size());
    for (int i = 0; i < ec.size() && i < cq.size(); i++) begin
      chk($sformatf("%s_cd%0d", tag, i), cq[i].d, ec[i].d);
      chk($sformatf("%s_cm%0d", tag, i), {cq[i].u, cq[i].k, cq[i].l}, {ec[i].u, ec[i].k, ec[i].l});
    end
    mq.delete();
    cq.delete();
    em.delete();
    ec.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    c_if.tready = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    chk("rst_mvld", m_if.tvalid, 1'b0);
    chk("rst_cvld", c_if.tvalid, 1'b0);
    chk("rst_srdy", s_if.tready, 1'b1);
    chk("rst_mdat", m_if.tdata, '0);
    chk("rst_cdat", c_if.tdata, '0);
    chk("rst_stats", {st_d, st_c, st_dr}, '0);
    aresetn = 1'b1;
    @(posedge axis_clk);
    #1;

    // 3-beat data packet with cycle-exact latency check on beat 1
    b = mk_beat(1, 0, 3, 1, 1, 16'h1234);
    em.push_back(b);
    send_beat(b);
    chk("t1_hold_mvld", m_if.tvalid, 1'b0);
    b = mk_beat(1, 1, 3, 1, 1, 16'h1234);
    em.push_back(b);
    send_beat(b);
    chk("t1_lat_vld", m_if.tvalid, 1'b1);
    chk("t1_lat_dat", m_if.tdata, em[0].d);
    chk("t1_lat_cvld", c_if.tvalid, 1'b0);
    b = mk_beat(1, 2, 3, 1, 1, 16'h1234);
    em.push_back(b);
    send_beat(b);
    s_if.tvalid = 1'b0;
    drain();
    cmp_q("t1");
    chk("t1_stat_data", st_d, 32'(1 * SE));

    // control packet
    send_pkt(2, 3, 1, 1, 16'hf1f2, 1);
    s_if.tvalid = 1'b0;
    drain();
    cmp_q("t2");
    chk("t2_stat_ctrl", st_c, 32'(1 * SE));

    // non-VLAN packet, then a single-beat packet: both dropped, no stalls
    stall_cnt = 0;
    send_pkt(3, 2, 0, 1, 16'hf1f2, 2);
    send_pkt(4, 1, 1, 1, 16'h1234, 2);
    s_if.tvalid = 1'b0;
    drain();
    chk("t3_no_stall", stall_cnt, 0);
    cmp_q("t3");
    chk("t3_stat_drop", st_dr, 32'(2 * SE));

    // control port number but TCP: stays on the data path
    send_pkt(5, 2, 1, 0, 16'hf1f2, 0);
    s_if.tvalid = 1'b0;
    drain();
    cmp_q("t3b");

    // data packet under toggling backpressure
    tog = 1'b1;
    send_pkt(6, 5, 1, 1, 16'h0050, 0);
    s_if.tvalid = 1'b0;
    drain();
    cmp_q("t4");

    // data, control, data back-to-back
    stall_cnt = 0;
    send_pkt(7, 4, 1, 1, 16'h0035, 0);
    send_pkt(8, 2, 1, 1, 16'hf1f2, 1);
    send_pkt(9, 3, 1, 0, 16'h0035, 0);
    s_if.tvalid = 1'b0;
    drain();
    cmp_q("t5");
    chk("t5_bubbles", (stall_cnt <= 2), 1'b1);
    chk("t5_stat_data", st_d, 32'(5 * SE));
    chk("t5_stat_ctrl", st_c, 32'(2 * SE));
    chk("t5_stat_drop", st_dr, 32'(2 * SE));

    // reset while beat 2 of a data packet is presented
    b = mk_beat(10, 0, 3, 1, 1, 16'h1234);
    send_beat(b);
    b = mk_beat(10, 1, 3, 1, 1, 16'h1234);
    s_if.tdata  = b.d;
    s_if.tuser  = b.u;
    s_if.tkeep  = b.k;
    s_if.tlast  = b.l;
    s_if.tvalid = 1'b1;
    aresetn     = 1'b0;
    @(posedge axis_clk);
    #1;
    chk("t6_mvld", m_if.tvalid, 1'b0);
    chk("t6_cvld", c_if.tvalid, 1'b0);
    chk("t6_srdy", s_if.tready, 1'b1);
    chk("t6_stats", {st_d, st_c, st_dr}, '0);
    aresetn     = 1'b1;
    s_if.tvalid = 1'b0;
    @(posedge axis_clk);
    #1;
    send_pkt(11, 3, 1, 1, 16'h1234, 0);
    s_if.tvalid = 1'b0;
    drain();
    cmp_q("t6");
    chk("t6_stat_data", st_d, 32'(1 * SE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
